btn_debounce_pulse: RTL and testbench

BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

---
 rtl/btn_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 31 +++
 rtl/btn_debounce_pulse.sv | 152 +++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button debouncer:
//   - FSM state encoding used by btn_debounce_pulse
//   - default values of the timing parameters (100 MHz clock)
//   - helpers that size the cycle counters
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,   // button released and stable
        PRESS_CHK = 2'd1,   // rising level seen, qualifying it
        HELD      = 2'd2,   // press accepted, button stable high
        REL_CHK   = 2'd3    // falling level seen, qualifying it
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 25_000_000;  // 250 ms

    // Counter width able to hold 0 .. max_value-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_value);
        return (max_value < 2) ? 1 : $clog2(max_value);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing a 1-bit asynchronous signal into CLK.
// Ports:
//   CLK  in   clock, rising edge
//   RST  in   synchronous active-high reset, clears both flops
//   d    in   asynchronous input
//   q    out  synchronized output (two CLK cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs at the same edge and form a real two-stage chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
// Debounces a raw push-button and produces registered level / press / release
// signals. A level change is accepted only after it has been stable for
// DEBOUNCE_CYCLES counted cycles; a bounce back restarts qualification.
//
// Optional feature (macro BTN_AUTOREPEAT_EN): while the button is held, extra
// btn_pulse events are produced REPEAT_DELAY cycles after the accepting pulse
// and then every REPEAT_PERIOD cycles. Without the macro the repeat logic and
// its parameters do not exist.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (2 .. 2**24)
//   REPEAT_DELAY     press -> first repeat pulse (macro only, >= 2)
//   REPEAT_PERIOD    cycles between repeat pulses (macro only, >= 2)
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   BTN          in   raw asynchronous bouncing button
//   btn_level    out  debounced button level (registered)
//   btn_pulse    out  one-cycle press event (registered)
//   btn_release  out  one-cycle release event (registered)
// -----------------------------------------------------------------------------
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned CNT_W = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
`else
    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
`endif

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_in;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] db_cnt;
    logic             rpt_fire;
    logic             level_nxt;
    logic             pulse_nxt;
    logic             release_nxt;

    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (BTN),
        .q   (sync_in)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // ----------------------------------------------------------- next state
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (sync_in) state_nxt = PRESS_CHK;
            PRESS_CHK: begin
                if (!sync_in)              state_nxt = IDLE;
                else if (db_cnt == DB_LAST) state_nxt = HELD;
            end
            HELD:      if (!sync_in) state_nxt = REL_CHK;
            REL_CHK: begin
                if (sync_in)               state_nxt = HELD;
                else if (db_cnt == DB_LAST) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------ stable counter
    // Cleared on every state change, so each qualification window starts at
    // zero; it stops at DB_LAST instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_cnt <= '0;
        end else if (state_nxt != state) begin
            db_cnt <= '0;
        end else if ((state == PRESS_CHK || state == REL_CHK) && db_cnt != DB_LAST) begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------ auto-repeat
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_periodic;   // first repeat already issued
    logic [CNT_W-1:0] rpt_last;

    assign rpt_last = rpt_periodic ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
    assign rpt_fire = (state == HELD) && (state_nxt == HELD) && (rpt_cnt == rpt_last);

    // Restarts from REPEAT_DELAY on every (re)entry into HELD.
    always_ff @(posedge CLK) begin
        if (RST || state != HELD || state_nxt != HELD) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b1;
        end else if (rpt_cnt != rpt_last) begin
            rpt_cnt      <= rpt_cnt + CNT_W'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // -------------------------------------------------------------- outputs
    always_comb begin
        level_nxt   = (state_nxt == HELD) || (state_nxt == REL_CHK);
        pulse_nxt   = ((state == PRESS_CHK) && (state_nxt == HELD)) || rpt_fire;
        release_nxt = (state == REL_CHK) && (state_nxt == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= level_nxt;
            btn_pulse   <= pulse_nxt;
            btn_release <= release_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
// Self-checking bench for btn_debounce_pulse (DEBOUNCE_CYCLES=4, and with
// BTN_AUTOREPEAT_EN also REPEAT_DELAY=20, REPEAT_PERIOD=8). A behavioural
// model predicts every output cycle from run lengths of the observed input;
// directed windows additionally pin the cycle numbers of key events.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

    localparam int DB = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int S1_PULSES = 2;   // cycles 6 and 26 within 30 held cycles
`else
    localparam int S1_PULSES = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN = 1'b0;
    logic btn_level, btn_pulse, btn_release;

    always #5 CLK = ~CLK;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (DB)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN         (BTN),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_release (btn_release)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    // The debouncer sees BTN two edges late (zero if a reset hit either
    // synchronizer edge). The level flips once the seen value has differed
    // from it for DB+1 consecutive edges. With auto-repeat, pulses come at
    // hold ages RD, RD+RP, RD+2RP, ... measured from acceptance or from a
    // return to stable high after a short dip.
    logic h_b1 = 1'b0, h_b2 = 1'b0, h_r1 = 1'b1, h_r2 = 1'b1;
    logic m_level = 1'b0, m_pulse = 1'b0, m_rel = 1'b0;
    int   run = 0;
    int   age = 0;

    task automatic model_edge(input logic b, input logic r);
        logic seen;
        seen    = (h_r1 || h_r2) ? 1'b0 : h_b2;
        m_pulse = 1'b0;
        m_rel   = 1'b0;
        if (r) begin
            m_level = 1'b0;
            run     = 0;
            age     = 0;
        end else if (seen != m_level) begin
            run++;
            if (run == DB + 1) begin
                m_level = seen;
                run     = 0;
                age     = 0;
                if (seen) m_pulse = 1'b1;
                else      m_rel   = 1'b1;
            end
        end else begin
            if (m_level && run > 0) begin
                age = 0;
            end else if (m_level) begin
                age++;
`ifdef BTN_AUTOREPEAT_EN
                if (age == RD || (age > RD && (age - RD) % RP == 0)) m_pulse = 1'b1;
`endif
            end
            run = 0;
        end
        h_b2 = h_b1; h_b1 = b;
        h_r2 = h_r1; h_r1 = r;
    endtask

    // ----------------------------------------------------------- stimulus
    int idx;
    int n_pulse, n_rel, n_low;
    int pulse_at[$];
    int rel_at[$];

    task automatic open_window();
        idx = 0; n_pulse = 0; n_rel = 0; n_low = 0;
        pulse_at.delete();
        rel_at.delete();
    endtask

    task automatic step(input logic b, input logic r);
        BTN = b;
        RST = r;
        @(posedge CLK);
        model_edge(b, r);
        @(negedge CLK);
        check("btn_level",   int'(btn_level),   int'(m_level));
        check("btn_pulse",   int'(btn_pulse),   int'(m_pulse));
        check("btn_release", int'(btn_release), int'(m_rel));
        if (btn_pulse === 1'b1)   begin n_pulse++; pulse_at.push_back(idx); end
        if (btn_release === 1'b1) begin n_rel++;   rel_at.push_back(idx);   end
        if (btn_level !== 1'b1)   n_low++;
        idx++;
    endtask

    task automatic repeat_step(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    int   exp_q[$];
    logic tgt;
    int   nb, hold;

    initial begin
        @(negedge CLK);
        // Reset state
        repeat (3) step(1'b0, 1'b1);
        check("reset_level",   int'(btn_level),   0);
        check("reset_pulse",   int'(btn_pulse),   0);
        check("reset_release", int'(btn_release), 0);

        // Clean press held 30 cycles, then release
        open_window();
        repeat_step(1'b1, 30);
        check("clean_first_pulse", first_of(pulse_at), 6);
        check("clean_pulse_count", n_pulse, S1_PULSES);
        check("clean_low_cycles",  n_low, 6);
        repeat_step(1'b0, 10);
        check("clean_release_at",  first_of(rel_at), 36);
        check("clean_release_cnt", n_rel, 1);

        // Bounce 1,0,1,0 then high
        open_window();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        repeat_step(1'b1, 16);
        check("bounce_first_pulse", first_of(pulse_at), 10);
        check("bounce_pulse_count", n_pulse, 1);
        repeat_step(1'b0, 10);

        // Release glitch while held
        repeat_step(1'b1, 10);
        open_window();
        repeat_step(1'b0, 2);
        repeat_step(1'b1, 10);
        check("glitch_release_cnt", n_rel, 0);
        check("glitch_pulse_cnt",   n_pulse, 0);
        check("glitch_low_cycles",  n_low, 0);
        repeat_step(1'b0, 10);

        // Reset during press qualification
        open_window();
        repeat_step(1'b1, 3);
        step(1'b1, 1'b1);
        repeat_step(1'b1, 12);
        check("rstmid_first_pulse", first_of(pulse_at), 10);
        check("rstmid_pulse_count", n_pulse, 1);
        repeat_step(1'b0, 10);

        // Long hold: auto-repeat pattern
        open_window();
        repeat_step(1'b1, 60);
`ifdef BTN_AUTOREPEAT_EN
        exp_q = '{6, 26, 34, 42, 50, 58};
`else
        exp_q = '{6};
`endif
        check("hold_pulse_count", pulse_at.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pulse_at.size(); i++)
            check("hold_pulse_cycle", pulse_at[i], exp_q[i]);
        repeat_step(1'b0, 10);

        // Randomized bouncing with occasional resets, checked every cycle
        for (int n = 0; n < 80; n++) begin
            tgt  = 1'($urandom_range(0, 1));
            nb   = int'($urandom_range(0, 6));
            hold = int'($urandom_range(1, 40));
            for (int i = 0; i < nb; i++) step(1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < hold; i++) step(tgt, ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
